// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: shares one BurstRAM between an instruction cache (port 0)
// and a data cache (port 1). Each port can queue one command. A winner is
// issued to the RAM. Write beats and read-valid strobes are steered to the
// port that owns the burst.
//
// Optional feature macro: BURST_RAM_ARBITER_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration; the last owner loses a tie
//   undefined -> fixed priority; port 0 wins a tie (no priority register)
//
// state  | meaning
// IDLE   | wait for a pending request while the RAM is not busy
// ISSUE  | one-cycle br_cmd_en; first write beat when the command is a write
// READ   | forward br_rd_data_valid beats to the owner
// WRITE  | remaining write beats, then wait for br_busy to drop
// DONE   | owner's pending entry already cleared; return to IDLE

module burst_ram_arbiter #(
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic                               p0_cmd,
    input  logic                               p0_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]      p0_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0] p0_wr_data,
    output logic                               p0_wr_beat,
    output logic                               p0_rd_data_valid,
    output logic                               p0_busy,

    input  logic                               p1_cmd,
    input  logic                               p1_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]      p1_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0] p1_wr_data,
    output logic                               p1_wr_beat,
    output logic                               p1_rd_data_valid,
    output logic                               p1_busy,

    output logic [RAM_BURST_DATA_BITWIDTH-1:0] rd_data,

    output logic                               br_cmd,
    output logic                               br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]      br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0] br_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0] br_rd_data,
    input  logic                               br_rd_data_valid,
    input  logic                               br_busy
);

    localparam int CW = (RAM_BURST_DATA_COUNT > 1) ? $clog2(RAM_BURST_DATA_COUNT) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(RAM_BURST_DATA_COUNT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]                    state;
    logic                          owner;
    logic                          own_cmd;
    logic [RAM_DEPTH_BITWIDTH-1:0] own_addr;
    logic [CW-1:0]                 beat_cnt;
    logic                          beats_done;

    logic [1:0]                    pend_v;
    logic [1:0]                    pend_cmd;
    logic [RAM_DEPTH_BITWIDTH-1:0] pend_addr0;
    logic [RAM_DEPTH_BITWIDTH-1:0] pend_addr1;

    logic [1:0]                    acc;
    logic [1:0]                    req;
    logic                          pick;
    logic                          pick_cmd;
    logic [RAM_DEPTH_BITWIDTH-1:0] pick_addr;
    logic                          grant;
    logic                          to_done;
    logic                          issue;
    logic                          wr_beat;
    logic                          rd_valid;

`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
    logic prio;

    // Priority pointer: after a grant the other port is preferred on a tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prio <= 1'b0;
        else if (grant)
            prio <= ~pick;
    end
`endif

    // Request acceptance, bypass of this cycle's strobe, and winner selection.
    always_comb begin
        acc = {p1_cmd_en & ~pend_v[1], p0_cmd_en & ~pend_v[0]};
        req = pend_v | acc;
`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
        pick = (req == 2'b11) ? prio : req[1] & ~req[0];
`else
        pick = ~req[0];
`endif
        if (pick) begin
            pick_cmd  = pend_v[1] ? pend_cmd[1] : p1_cmd;
            pick_addr = pend_v[1] ? pend_addr1  : p1_addr;
        end else begin
            pick_cmd  = pend_v[0] ? pend_cmd[0] : p0_cmd;
            pick_addr = pend_v[0] ? pend_addr0  : p0_addr;
        end
        grant   = (state == S_IDLE) && (|req) && !br_busy;
        to_done = ((state == S_READ) && br_rd_data_valid && (beat_cnt == LAST_BEAT)) ||
                  ((state == S_WRITE) && beats_done && !br_busy);
    end

    // Pending registers: set on an accepted strobe, cleared as the owner enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v     <= 2'b00;
            pend_cmd   <= 2'b00;
            pend_addr0 <= '0;
            pend_addr1 <= '0;
        end else begin
            if (acc[0]) begin
                pend_cmd[0] <= p0_cmd;
                pend_addr0  <= p0_addr;
            end
            if (acc[1]) begin
                pend_cmd[1] <= p1_cmd;
                pend_addr1  <= p1_addr;
            end
            pend_v[0] <= (pend_v[0] & ~(to_done & ~owner)) | acc[0];
            pend_v[1] <= (pend_v[1] & ~(to_done &  owner)) | acc[1];
        end
    end

    // Burst sequencing FSM with beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            own_cmd    <= 1'b0;
            own_addr   <= '0;
            beat_cnt   <= '0;
            beats_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        owner      <= pick;
                        own_cmd    <= pick_cmd;
                        own_addr   <= pick_addr;
                        beat_cnt   <= '0;
                        beats_done <= 1'b0;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (own_cmd) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        state    <= S_WRITE;
                    end else begin
                        state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (br_rd_data_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT)
                            state <= S_DONE;
                    end
                end
                S_WRITE: begin
                    if (!beats_done) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT)
                            beats_done <= 1'b1;
                    end else if (!br_busy) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output steering toward the RAM and the owning port.
    always_comb begin
        issue      = (state == S_ISSUE);
        wr_beat    = (issue && own_cmd) || ((state == S_WRITE) && !beats_done);
        rd_valid   = (state == S_READ) && br_rd_data_valid;
        br_cmd_en  = issue;
        br_cmd     = issue & own_cmd;
        br_addr    = issue ? own_addr : '0;
        br_wr_data = wr_beat ? (owner ? p1_wr_data : p0_wr_data) : '0;
        p0_wr_beat       = wr_beat & ~owner;
        p1_wr_beat       = wr_beat &  owner;
        p0_rd_data_valid = rd_valid & ~owner;
        p1_rd_data_valid = rd_valid &  owner;
        p0_busy    = pend_v[0];
        p1_busy    = pend_v[1];
        rd_data    = br_rd_data;
    end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter; the RAM response side is driven by hand.
module tb_burst_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_cmd, p0_cmd_en, p1_cmd, p1_cmd_en;
    logic [3:0]  p0_addr, p1_addr;
    logic [63:0] p0_wr_data, p1_wr_data;
    logic        p0_wr_beat, p0_rd_data_valid, p0_busy;
    logic        p1_wr_beat, p1_rd_data_valid, p1_busy;
    logic [63:0] rd_data;
    logic        br_cmd, br_cmd_en;
    logic [3:0]  br_addr;
    logic [63:0] br_wr_data, br_rd_data;
    logic        br_rd_data_valid, br_busy;

    int errors = 0;
    int checks = 0;
    int first_own;

    always #5 clk = ~clk;

    burst_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_cmd(p0_cmd), .p0_cmd_en(p0_cmd_en), .p0_addr(p0_addr), .p0_wr_data(p0_wr_data),
        .p0_wr_beat(p0_wr_beat), .p0_rd_data_valid(p0_rd_data_valid), .p0_busy(p0_busy),
        .p1_cmd(p1_cmd), .p1_cmd_en(p1_cmd_en), .p1_addr(p1_addr), .p1_wr_data(p1_wr_data),
        .p1_wr_beat(p1_wr_beat), .p1_rd_data_valid(p1_rd_data_valid), .p1_busy(p1_busy),
        .rd_data(rd_data),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
        .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the ISSUE cycle; RAM goes busy from the next cycle.
    task automatic issue_check(input string tag, input logic [3:0] addr, input logic cmd);
        #1;
        chk({tag, "_cmd_en"}, 64'(br_cmd_en), 64'd1);
        chk({tag, "_addr"},   64'(br_addr),   64'(addr));
        chk({tag, "_cmd"},    64'(br_cmd),    64'(cmd));
        br_busy = 1'b1;
    endtask

    // Called in the first READ cycle; ends in the IDLE cycle after DONE.
    task automatic read_beats(input string tag, input int own, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            br_rd_data_valid = 1'b1;
            br_rd_data = 64'h11 * 64'(i + 1);
            #1;
            chk({tag, "_valid"}, 64'({p1_rd_data_valid, p0_rd_data_valid}),
                (own == 1) ? 64'd2 : 64'd1);
            chk({tag, "_rd_data"}, rd_data, 64'h11 * 64'(i + 1));
            step();
        end
        br_rd_data_valid = 1'b0;
        br_busy = 1'b0;
        #1;
        chk({tag, "_busy_done"}, 64'((own == 1) ? p1_busy : p0_busy), 64'd0);
        chk({tag, "_no_cmd_done"}, 64'(br_cmd_en), 64'd0);
        step();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        p0_cmd = 0; p0_cmd_en = 0; p0_addr = 0; p0_wr_data = 64'hDEAD;
        p1_cmd = 0; p1_cmd_en = 0; p1_addr = 0; p1_wr_data = 0;
        br_rd_data = 0; br_rd_data_valid = 0; br_busy = 0;
        #12;
        chk("reset_busy",   64'({p1_busy, p0_busy}), 64'd0);
        chk("reset_cmd_en", 64'(br_cmd_en), 64'd0);
        chk("reset_wr",     64'({p1_wr_beat, p0_wr_beat}), 64'd0);
        step();
        rst = 1'b0;

        // Single read, port 0, addr 3.
        p0_cmd = 0; p0_cmd_en = 1; p0_addr = 4'h3;
        #1 chk("rd_lat_idle", 64'(br_cmd_en), 64'd0);
        step();
        p0_cmd_en = 0;
        chk("rd_busy_rise", 64'(p0_busy), 64'd1);
        issue_check("rd", 4'h3, 1'b0);
        step();
        chk("rd_no_reissue", 64'(br_cmd_en), 64'd0);
        read_beats("rd", 0, 4);

        // Write, port 1, addr 9, beats A0..A3.
        p1_cmd = 1; p1_cmd_en = 1; p1_addr = 4'h9; p1_wr_data = 64'hA0;
        step();
        p1_cmd_en = 0;
        issue_check("wr", 4'h9, 1'b1);
        chk("wr_beat0", 64'({p1_wr_beat, p0_wr_beat}), 64'd2);
        chk("wr_data0", br_wr_data, 64'hA0);
        for (int i = 1; i < 4; i++) begin
            step();
            p1_wr_data = 64'hA0 + 64'(i);
            #1;
            chk("wr_beat", 64'({p1_wr_beat, p0_wr_beat}), 64'd2);
            chk("wr_data", br_wr_data, 64'hA0 + 64'(i));
        end
        step();
        chk("wr_beat_end", 64'(p1_wr_beat), 64'd0);
        chk("wr_data_end", br_wr_data, 64'd0);
        chk("wr_busy_hold", 64'(p1_busy), 64'd1);
        step();
        chk("wr_busy_hold2", 64'(p1_busy), 64'd1);
        br_busy = 0;
        step();
        chk("wr_busy_clear", 64'(p1_busy), 64'd0);
        step();

        // Simultaneous reads: p0 addr 1, p1 addr 2 -> p0 first in both modes.
        p0_cmd = 0; p0_cmd_en = 1; p0_addr = 4'h1;
        p1_cmd = 0; p1_cmd_en = 1; p1_addr = 4'h2;
        step();
        p0_cmd_en = 0; p1_cmd_en = 0;
        chk("pair1_both_busy", 64'({p1_busy, p0_busy}), 64'd3);
        issue_check("pair1_a", 4'h1, 1'b0);
        step();
        read_beats("pair1_a", 0, 4);
        chk("pair1_loser_busy", 64'(p1_busy), 64'd1);
        step();
        issue_check("pair1_b", 4'h2, 1'b0);
        step();
        read_beats("pair1_b", 1, 4);

        // Enqueue during burst plus a dropped strobe on the busy port.
        p0_cmd = 0; p0_cmd_en = 1; p0_addr = 4'h5;
        step();
        p0_cmd_en = 0;
        issue_check("enq_a", 4'h5, 1'b0);
        p0_cmd_en = 1; p0_addr = 4'hF;
        p1_cmd = 0; p1_cmd_en = 1; p1_addr = 4'h7;
        step();
        p0_cmd_en = 0; p1_cmd_en = 0;
        chk("enq_p1_busy", 64'(p1_busy), 64'd1);
        read_beats("enq_a", 0, 4);
        step();
        issue_check("enq_b", 4'h7, 1'b0);
        chk("drop_p0_idle", 64'(p0_busy), 64'd0);
        step();
        read_beats("enq_b", 1, 4);
        chk("drop_no_extra_cmd", 64'(br_cmd_en), 64'd0);
        step();
        chk("drop_no_extra_cmd2", 64'(br_cmd_en), 64'd0);

        // Reset in the middle of a read after beat 2.
        p0_cmd = 0; p0_cmd_en = 1; p0_addr = 4'h6;
        step();
        p0_cmd_en = 0;
        issue_check("rst_rd", 4'h6, 1'b0);
        step();
        for (int i = 0; i < 2; i++) begin
            br_rd_data_valid = 1; br_rd_data = 64'h11 * 64'(i + 1);
            #1 chk("rst_rd_pre", 64'(p0_rd_data_valid), 64'd1);
            step();
        end
        br_rd_data = 64'h33;
        rst = 1'b1;
        #1;
        chk("rst_async_busy",  64'({p1_busy, p0_busy}), 64'd0);
        chk("rst_async_valid", 64'({p1_rd_data_valid, p0_rd_data_valid}), 64'd0);
        step();
        rst = 1'b0;
        br_rd_data = 64'h44;
        p0_cmd = 0; p0_cmd_en = 1; p0_addr = 4'hC;
        #1 chk("rst_late_beat", 64'({p1_rd_data_valid, p0_rd_data_valid}), 64'd0);
        step();
        br_rd_data_valid = 0; p0_cmd_en = 0;
        chk("rst_wait_busy", 64'(br_cmd_en), 64'd0);
        chk("rst_new_pending", 64'(p0_busy), 64'd1);
        step();
        chk("rst_wait_busy2", 64'(br_cmd_en), 64'd0);
        br_busy = 0;
        step();
        issue_check("rst_new", 4'hC, 1'b0);
        step();
        read_beats("rst_new", 0, 4);

        // Second simultaneous pair; last owner was port 0.
`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
        first_own = 1;
`else
        first_own = 0;
`endif
        p0_cmd = 0; p0_cmd_en = 1; p0_addr = 4'h1;
        p1_cmd = 0; p1_cmd_en = 1; p1_addr = 4'h2;
        step();
        p0_cmd_en = 0; p1_cmd_en = 0;
        issue_check("pair2_a", (first_own == 1) ? 4'h2 : 4'h1, 1'b0);
        step();
        read_beats("pair2_a", first_own, 4);
        step();
        issue_check("pair2_b", (first_own == 1) ? 4'h1 : 4'h2, 1'b0);
        step();
        read_beats("pair2_b", 1 - first_own, 4);
        chk("final_idle_busy", 64'({p1_busy, p0_busy}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
